reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised next-generation CPU register file: 2 async read ports, 1 sync write port,
//  write-to-read bypass, optional hard-wired zero register, per-register pending
//  (scoreboard) bits, and a multi-cycle bulk-clear sequencer.
//  Sits between decode (a1/a2/issue) and writeback (aWrite/dataIn/load) in the core datapath.
// PARAMETERS
//  ADDR_W   3  register address width; DEPTH = 2**ADDR_W registers
//  DATA_W   8  register data width
//  ZERO_REG 0  1: reg 0 always reads 0; writes and issues to reg 0 are ignored
//  BYPASS   1  1: same-cycle write data forwarded to read ports; 0: read old contents
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       asynchronous, active-high reset
//  a1, a2    in   ADDR_W  read addresses
//  out1,out2 out  DATA_W  read data (combinational)
//  pend1,pend2 out 1      pending bit of register a1 / a2
//  aWrite    in   ADDR_W  write address
//  dataIn    in   DATA_W  write data
//  load      in   1       write enable
//  issue     in   1       mark register aIssue pending (result in flight)
//  aIssue    in   ADDR_W  register to mark pending
//  clrReq    in   1       start bulk clear (single-cycle pulse sufficient)
//  clrBusy   out  1       bulk clear in progress
// BEHAVIOUR
//  - Reset (async, rst=1): all registers 0, all pending bits 0, FSM IDLE, counter 0, clrBusy 0.
//  - Write: posedge with load=1 and clrBusy=0 -> reg[aWrite]<=dataIn, pending[aWrite]<=0.
//  - Read: outN = reg[aN]; if BYPASS and load and !clrBusy and aWrite==aN -> outN = dataIn.
//    ZERO_REG=1 and aN==0 -> outN = 0 (overrides bypass).
//  - pendN = pending[aN]; if BYPASS and qualifying write to aN this cycle -> pendN = 0.
//  - Issue: posedge with issue=1 and clrBusy=0 -> pending[aIssue]<=1.
//    issue and load to same register same cycle: data written AND pending set (issue wins).
//  - ZERO_REG=1: reg 0 never written, pending[0] never set.
//  - Clear FSM: IDLE --clrReq--> CLEAR (clrBusy=1 from next cycle); in CLEAR each cycle
//    reg[cnt]<=0, pending[cnt]<=0, cnt++; cnt==DEPTH-1 -> IDLE, cnt<=0.
//    Latency: DEPTH cycles busy; clrBusy deasserts the cycle after last register cleared.
//  - During CLEAR: load and issue ignored (dropped, not queued); clrReq ignored; bypass off;
//    reads return current, partially cleared contents.
//  - clrReq and load same cycle in IDLE: the write commits, then clearing starts next cycle.
//  - rst during CLEAR: aborts immediately to reset state.
//  - Counter is ADDR_W bits; no wrap beyond DEPTH-1.
// STRUCTURE
//  - Package regfile_pkg: state enum {IDLE, CLEAR}, localparam DEPTH=2**ADDR_W helper.
//  - Sub-module regfile_clr_seq: FSM + counter; outputs clrBusy, clrAddr, clrWe.
//  - Top: register array + pending vector, read muxes, bypass/zero logic, write arbitration.
// TESTING
//  1 rst=1 mid-operation -> all outN=0, pendN=0, clrBusy=0 at once, no clock needed.
//  2 load=1 aWrite=5 dataIn=8'hA5, a1=5 same cycle -> out1=A5 (BYPASS=1), old value (BYPASS=0);
//    after edge out1=A5 in both.
//  3 issue aIssue=3 -> pend1(a1=3)=1 next cycle; load aWrite=3 -> pend1=0 combinationally,
//    stays 0 after edge; issue+load to 3 together -> pend=1 after edge.
//  4 ZERO_REG=1: load aWrite=0 dataIn=FF, issue aIssue=0 -> out1(a1=0)=0, pend1=0 always.
//  5 fill regs 1..7, clrReq pulse -> clrBusy=1 for exactly 8 cycles; load during busy dropped;
//    all regs 0 and pending 0 afterwards.
//  6 rst asserted at clear cycle 3 -> all zero, clrBusy=0; new clrReq restarts from reg 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Number of registers addressable with addr_w bits.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: after a request, walks every register address
// once, asserting a clear strobe for one cycle per address.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam int unsigned       DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  clr_state_e        state;
  clr_state_e        state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Requests arriving while already clearing are dropped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) state_n = CLEAR;
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ADDR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // All outputs decode directly from flops.
  assign clr_busy = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one sync write port, optional
// write-to-read bypass and zero register, pending bits and bulk clear.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              pend1,
  output logic              pend2,
  input  logic [ADDR_W-1:0] aWrite,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              load,
  input  logic              issue,
  input  logic [ADDR_W-1:0] aIssue,
  input  logic              clrReq,
  output logic              clrBusy
);

  localparam int unsigned DEPTH   = depth_of(ADDR_W);
  localparam bit          HAS_ZR  = (ZERO_REG != 0);
  localparam bit          HAS_BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              byp_ok;
  logic              wr_en;
  logic              iss_en;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clrReq),
    .clr_busy (clrBusy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // Write/issue qualification: the clear sequencer owns the array while busy.
  assign byp_ok = load && !clrBusy;
  assign wr_en  = byp_ok && !(HAS_ZR && (aWrite == '0));
  assign iss_en = issue && !clrBusy && !(HAS_ZR && (aIssue == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (clr_we) begin
      regs[clr_addr] <= '0;
    end else if (wr_en) begin
      regs[aWrite] <= dataIn;
    end
  end

  // Issue is applied after write so a same-register issue leaves it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (clr_we) begin
      pending[clr_addr] <= 1'b0;
    end else begin
      if (wr_en)  pending[aWrite] <= 1'b0;
      if (iss_en) pending[aIssue] <= 1'b1;
    end
  end

  // Read muxes; the zero register overrides any forwarded value.
  always_comb begin
    out1  = regs[a1];
    pend1 = pending[a1];
    out2  = regs[a2];
    pend2 = pending[a2];
    if (HAS_BYP && byp_ok && (aWrite == a1)) begin
      out1  = dataIn;
      pend1 = 1'b0;
    end
    if (HAS_BYP && byp_ok && (aWrite == a2)) begin
      out2  = dataIn;
      pend2 = 1'b0;
    end
    if (HAS_ZR && (a1 == '0)) begin
      out1  = '0;
      pend1 = 1'b0;
    end
    if (HAS_ZR && (a2 == '0)) begin
      out2  = '0;
      pend2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: two instances (bypass / zero-register)
// checked every cycle against an array model plus literal expectations.
module tb_reg_file_sb;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] a1, a2, aWrite, aIssue;
  logic [DW-1:0] dataIn;
  logic          load, issue, clrReq;

  logic [DW-1:0] out1_a, out2_a, out1_b, out2_b;
  logic          pend1_a, pend2_a, pend1_b, pend2_b;
  logic          busy_a, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance a: BYPASS=1, ZERO_REG=0.
  reg_file_sb #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .out1(out1_a), .out2(out2_a),
    .pend1(pend1_a), .pend2(pend2_a), .aWrite(aWrite), .dataIn(dataIn),
    .load(load), .issue(issue), .aIssue(aIssue), .clrReq(clrReq), .clrBusy(busy_a)
  );

  // Instance b: BYPASS=0, ZERO_REG=1.
  reg_file_sb #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .out1(out1_b), .out2(out2_b),
    .pend1(pend1_b), .pend2(pend2_b), .aWrite(aWrite), .dataIn(dataIn),
    .load(load), .issue(issue), .aIssue(aIssue), .clrReq(clrReq), .clrBusy(busy_b)
  );

  always #5 clk = ~clk;

  // Model: index 0 mirrors instance a, index 1 instance b. m_clr = next
  // register to clear, or -1 when no clear is running.
  logic [DW-1:0] m_reg  [2][DEPTH];
  bit            m_pend [2][DEPTH];
  int            m_clr  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_reg[m][i]  <= '0;
          m_pend[m][i] <= 1'b0;
        end
        m_clr[m] <= -1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_clr[m] >= 0) begin
          m_reg[m][m_clr[m]]  <= '0;
          m_pend[m][m_clr[m]] <= 1'b0;
          m_clr[m] <= (m_clr[m] == DEPTH - 1) ? -1 : m_clr[m] + 1;
        end else begin
          if (load && !(m == 1 && aWrite == 0)) begin
            m_reg[m][aWrite]  <= dataIn;
            m_pend[m][aWrite] <= 1'b0;
          end
          if (issue && !(m == 1 && aIssue == 0)) m_pend[m][aIssue] <= 1'b1;
          if (clrReq) m_clr[m] <= 0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_out(input int m, input logic [AW-1:0] a);
    if (m == 1 && a == 0) return '0;
    if (m == 0 && load && m_clr[m] < 0 && aWrite == a) return dataIn;
    return m_reg[m][a];
  endfunction

  function automatic logic exp_pend(input int m, input logic [AW-1:0] a);
    if (m == 1 && a == 0) return 1'b0;
    if (m == 0 && load && m_clr[m] < 0 && aWrite == a) return 1'b0;
    return m_pend[m][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out1_a", 32'(out1_a), 32'(exp_out(0, a1)));
    chk("out2_a", 32'(out2_a), 32'(exp_out(0, a2)));
    chk("pend1_a", 32'(pend1_a), 32'(exp_pend(0, a1)));
    chk("pend2_a", 32'(pend2_a), 32'(exp_pend(0, a2)));
    chk("busy_a", 32'(busy_a), 32'(m_clr[0] >= 0));
    chk("out1_b", 32'(out1_b), 32'(exp_out(1, a1)));
    chk("out2_b", 32'(out2_b), 32'(exp_out(1, a2)));
    chk("pend1_b", 32'(pend1_b), 32'(exp_pend(1, a1)));
    chk("pend2_b", 32'(pend2_b), 32'(exp_pend(1, a2)));
    chk("busy_b", 32'(busy_b), 32'(m_clr[1] >= 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear_done(input string name);
    int n = 0;
    while ((busy_a || busy_b) && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(busy_a || busy_b), 32'd0);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    a1 = '0; a2 = '0; aWrite = '0; aIssue = '0; dataIn = '0;
    load = 1'b0; issue = 1'b0; clrReq = 1'b0;
    #1 rst = 1'b1;
    #10 rst = 1'b0;
    chk("reset busy_a", 32'(busy_a), 32'd0);
    chk("reset out1_a", 32'(out1_a), 32'd0);

    // Bypass vs. no bypass on a fresh write.
    a1 = 3'd5; load = 1'b1; aWrite = 3'd5; dataIn = 8'hA5;
    #1;
    chk("t2 bypass out1_a", 32'(out1_a), 32'hA5);
    chk("t2 nobypass out1_b", 32'(out1_b), 32'h00);
    step(); load = 1'b0; #1;
    chk("t2 after out1_a", 32'(out1_a), 32'hA5);
    chk("t2 after out1_b", 32'(out1_b), 32'hA5);

    // Pending set by issue, cleared by write, issue wins on collision.
    a1 = 3'd3; issue = 1'b1; aIssue = 3'd3;
    step(); issue = 1'b0; #1;
    chk("t3 issued pend1_a", 32'(pend1_a), 32'd1);
    chk("t3 issued pend1_b", 32'(pend1_b), 32'd1);
    load = 1'b1; aWrite = 3'd3; dataIn = 8'h33; #1;
    chk("t3 bypass pend1_a", 32'(pend1_a), 32'd0);
    chk("t3 nobypass pend1_b", 32'(pend1_b), 32'd1);
    step(); load = 1'b0; #1;
    chk("t3 written pend1_a", 32'(pend1_a), 32'd0);
    chk("t3 written pend1_b", 32'(pend1_b), 32'd0);
    load = 1'b1; issue = 1'b1; aWrite = 3'd3; aIssue = 3'd3; dataIn = 8'h3C;
    step(); load = 1'b0; issue = 1'b0; #1;
    chk("t3 both pend1_a", 32'(pend1_a), 32'd1);
    chk("t3 both out1_a", 32'(out1_a), 32'h3C);
    chk("t3 both pend1_b", 32'(pend1_b), 32'd1);

    // Zero register ignores writes and issues.
    a1 = 3'd0; load = 1'b1; aWrite = 3'd0; dataIn = 8'hFF; issue = 1'b1; aIssue = 3'd0;
    #1;
    chk("t4 zr out1_b", 32'(out1_b), 32'h00);
    chk("t4 zr pend1_b", 32'(pend1_b), 32'd0);
    chk("t4 nz bypass out1_a", 32'(out1_a), 32'hFF);
    step(); load = 1'b0; issue = 1'b0; #1;
    chk("t4 zr after out1_b", 32'(out1_b), 32'h00);
    chk("t4 zr after pend1_b", 32'(pend1_b), 32'd0);
    chk("t4 nz after out1_a", 32'(out1_a), 32'hFF);
    chk("t4 nz after pend1_a", 32'(pend1_a), 32'd1);

    // Fill, then bulk clear with loads/issues attempted while busy.
    for (int i = 1; i < DEPTH; i++) begin
      load = 1'b1; aWrite = AW'(i); dataIn = DW'(8'h10 + i);
      issue = 1'b1; aIssue = AW'(i);
      step();
    end
    load = 1'b0; issue = 1'b0; a1 = 3'd7; a2 = 3'd2;
    #1;
    chk("t5 filled out1_a", 32'(out1_a), 32'h17);
    clrReq = 1'b1;
    step(); clrReq = 1'b0;
    load = 1'b1; aWrite = 3'd2; dataIn = 8'h77; issue = 1'b1; aIssue = 3'd6;
    cnt_a = 0; cnt_b = 0;
    for (int n = 0; n < 20 && (busy_a || busy_b); n++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      step();
    end
    load = 1'b0; issue = 1'b0;
    chk("t5 busy cycles a", 32'(cnt_a), 32'd8);
    chk("t5 busy cycles b", 32'(cnt_b), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      a1 = AW'(i); a2 = AW'(i); #1;
      chk("t5 cleared out1_a", 32'(out1_a), 32'h00);
      chk("t5 cleared pend1_a", 32'(pend1_a), 32'd0);
      chk("t5 cleared out2_b", 32'(out2_b), 32'h00);
      chk("t5 cleared pend2_b", 32'(pend2_b), 32'd0);
    end

    // Reset during clear, then a fresh clear starts at register 0.
    for (int i = 0; i < DEPTH; i++) begin
      load = 1'b1; aWrite = AW'(i); dataIn = DW'(8'h20 + i);
      step();
    end
    load = 1'b0; a1 = 3'd5; a2 = 3'd7;
    clrReq = 1'b1;
    step(); clrReq = 1'b0;
    step(); step(); step();
    chk("t6 still busy", 32'(busy_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst busy_a", 32'(busy_a), 32'd0);
    chk("t6 rst busy_b", 32'(busy_b), 32'd0);
    chk("t6 rst out1_a", 32'(out1_a), 32'h00);
    chk("t6 rst out2_b", 32'(out2_b), 32'h00);
    #3 rst = 1'b0;
    load = 1'b1; aWrite = 3'd0; dataIn = 8'h5A;
    step();
    aWrite = 3'd1; dataIn = 8'h61;
    step();
    load = 1'b0; clrReq = 1'b1;
    step(); clrReq = 1'b0;
    step();
    a1 = 3'd0; a2 = 3'd1; #1;
    chk("t6 restart reg0 cleared", 32'(out1_a), 32'h00);
    chk("t6 restart reg1 kept", 32'(out2_a), 32'h61);
    wait_clear_done("t6 clear completes");

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
